// File: rtl/filter_frame_ctrl.sv
// -----------------------------------------------------------------------------
// filter_frame_ctrl
//
// Frame sequencer that sits between a pixel source and a 3x3-style line-buffer
// filter. It accepts a frame request, validates the geometry, clears the
// filter, streams W*H source pixels into it, pushes a few zero pixels to drain
// the filter pipeline, and then waits for the filter's results. Every result
// is tagged with start-of-frame, end-of-line and end-of-frame markers.
//
// Parameters
//   MAX_WIDTH  largest legal frame width (the filter's line-buffer depth)
//   FLUSH_LEN  number of zero-pixel strobes sent after the last real pixel
//   DRAIN_MAX  maximum cycles spent waiting for results before giving up
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_width, cfg_height    frame geometry, captured when a start is accepted
//   start, abort             single-cycle frame request / frame cancel
//   busy                     high whenever a frame is in progress
//   done, aborted, cfg_err   single-cycle completion / cancel / bad-config pulses
//   s_pixel, s_valid, s_ready  source pixel stream (valid/ready)
//   f_data, f_valid, f_clr     filter pixel input, pixel strobe, per-frame clear
//   f_out, f_out_valid         filter result stream
//   m_data, m_valid            tagged result stream
//   m_sof, m_eol, m_eof        first result, last result of a line, last result
// -----------------------------------------------------------------------------
module filter_frame_ctrl #(
   parameter int unsigned MAX_WIDTH = 1024,
   parameter int unsigned FLUSH_LEN = 2,
   parameter int unsigned DRAIN_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] cfg_width,
   input  logic [11:0] cfg_height,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        aborted,
   output logic        cfg_err,
   input  logic [7:0]  s_pixel,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [7:0]  f_data,
   output logic        f_valid,
   output logic        f_clr,
   input  logic [7:0]  f_out,
   input  logic        f_out_valid,
   output logic [7:0]  m_data,
   output logic        m_valid,
   output logic        m_sof,
   output logic        m_eol,
   output logic        m_eof
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_WAIT  = 3'd4
   } state_t;

   // Terminal values of the flush and drain counters.
   localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_LEN - 1);
   localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_MAX - 1);

   state_t      state;
   state_t      state_nxt;

   // Frame geometry captured at start; widths and heights are kept as
   // "minus one" so the wrap comparisons need no subtractor.
   logic [11:0] width_m1;
   logic [11:0] height_m1;
   logic [23:0] total;

   logic [11:0] in_col;
   logic [11:0] in_row;
   logic [23:0] out_cnt;
   logic [11:0] out_col;
   logic [15:0] flush_cnt;
   logic [15:0] wait_cnt;

   logic        cfg_ok;
   logic        start_ok;
   logic        xfer;
   logic        last_pix;
   logic        flush_end;
   logic        wait_end;
   logic        tag_en;

   // Shared decode terms. The width bound is compared at 32 bits so that a
   // MAX_WIDTH larger than the 12-bit port range still behaves sensibly.
   // A result is only tagged while a frame is live and still short of its
   // expected count; an abort in the same cycle drops it.
   always_comb begin
      cfg_ok    = (cfg_width >= 12'd3) &&
                  (32'(cfg_width) <= MAX_WIDTH) &&
                  (cfg_height >= 12'd3);
      start_ok  = (state == S_IDLE) && start && cfg_ok;
      xfer      = s_valid && s_ready;
      last_pix  = (in_col == width_m1) && (in_row == height_m1);
      flush_end = (flush_cnt == FLUSH_LAST);
      wait_end  = (out_cnt == total) || (wait_cnt == DRAIN_LAST);
      tag_en    = busy && f_out_valid && (out_cnt < total) && !abort;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Abort overrides every busy state; in IDLE it is
   // ignored so a simultaneous start always wins.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start && cfg_ok) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            state_nxt = S_RUN;
         end
         S_RUN: begin
            if (xfer && last_pix) begin
               state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (flush_end) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_end) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if ((state != S_IDLE) && abort) begin
         state_nxt = S_IDLE;
      end
   end

   // Moore-style control outputs plus the pass-through pixel path. In RUN the
   // filter strobe follows the source handshake directly; in FLUSH it is
   // forced high with zero data to push the last real pixels out.
   always_comb begin
      busy    = (state != S_IDLE);
      s_ready = (state == S_RUN);
      f_clr   = (state == S_LOAD);
      f_valid = (s_valid && s_ready) || (state == S_FLUSH);
      f_data  = (state == S_RUN) ? s_pixel : 8'd0;
   end

   // Single-cycle status pulses, all registered so they appear in the cycle
   // after the event that caused them. Reset suppresses every pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         done    <= 1'b0;
         aborted <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         done    <= (state == S_WAIT) && wait_end && !abort;
         aborted <= busy && abort;
         cfg_err <= (state == S_IDLE) && start && !cfg_ok;
      end
   end

   // Frame geometry capture and the input-side counters. TOTAL is the number
   // of filter results expected: the first two rows only prime the line
   // buffers, so each remaining row yields one line of W results.
   always_ff @(posedge clk) begin
      if (rst) begin
         width_m1  <= '0;
         height_m1 <= '0;
         total     <= '0;
         in_col    <= '0;
         in_row    <= '0;
         flush_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         if (start_ok) begin
            width_m1  <= cfg_width - 12'd1;
            height_m1 <= cfg_height - 12'd1;
            total     <= 24'(cfg_width) * 24'(cfg_height - 12'd2);
         end
         case (state)
            S_LOAD: begin
               in_col    <= '0;
               in_row    <= '0;
               flush_cnt <= '0;
               wait_cnt  <= '0;
            end
            S_RUN: begin
               if (xfer) begin
                  if (in_col == width_m1) begin
                     in_col <= '0;
                     in_row <= in_row + 12'd1;
                  end else begin
                     in_col <= in_col + 12'd1;
                  end
               end
            end
            S_FLUSH: begin
               flush_cnt <= flush_cnt + 16'd1;
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt + 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Output-side counters. These are zeroed on the accepting start edge
   // rather than during LOAD, so they already read zero for the whole LOAD
   // cycle and any result arriving then is tagged against a clean count.
   // out_col tracks the result column with a wrap instead of a modulo.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_cnt <= '0;
         out_col <= '0;
      end else if (start_ok) begin
         out_cnt <= '0;
         out_col <= '0;
      end else if (tag_en) begin
         out_cnt <= out_cnt + 24'd1;
         if (out_col == width_m1) begin
            out_col <= '0;
         end else begin
            out_col <= out_col + 12'd1;
         end
      end
   end

   // Tagged result register: one cycle of latency from the filter result.
   // Idle cycles drive zeros on every field so nothing stale is presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= 8'd0;
         m_sof   <= 1'b0;
         m_eol   <= 1'b0;
         m_eof   <= 1'b0;
      end else if (tag_en) begin
         m_valid <= 1'b1;
         m_data  <= f_out;
         m_sof   <= (out_cnt == 24'd0);
         m_eol   <= (out_col == width_m1);
         m_eof   <= (out_cnt == total - 24'd1);
      end else begin
         m_valid <= 1'b0;
         m_data  <= 8'd0;
         m_sof   <= 1'b0;
         m_eol   <= 1'b0;
         m_eof   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_filter_frame_ctrl
//
// Directed bench for filter_frame_ctrl. A small behavioural filter model
// answers the pixel strobes: it counts strobes since the last clear and emits
// one result per strobe once the count reaches mdl_skip, up to mdl_limit
// results, with data 0x40, 0x41, ... so every tagged beat is identifiable.
// A sampling task records what the DUT does each cycle; the test tasks drive
// frames and compare the recording against hand-computed values.
// -----------------------------------------------------------------------------
module tb_filter_frame_ctrl;

   logic        clk         = 1'b0;
   logic        rst         = 1'b1;
   logic [11:0] cfg_width   = 12'd0;
   logic [11:0] cfg_height  = 12'd0;
   logic        start       = 1'b0;
   logic        abort       = 1'b0;
   logic [7:0]  s_pixel     = 8'd0;
   logic        s_valid     = 1'b0;
   logic [7:0]  f_out       = 8'd0;
   logic        f_out_valid = 1'b0;

   logic        busy;
   logic        done;
   logic        aborted;
   logic        cfg_err;
   logic        s_ready;
   logic [7:0]  f_data;
   logic        f_valid;
   logic        f_clr;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_sof;
   logic        m_eol;
   logic        m_eof;

   int n_cmp  = 0;
   int n_fail = 0;

   int mdl_skip  = 1000;
   int mdl_limit = 0;
   int mdl_cnt   = 0;
   int mdl_emit  = 0;

   int fv_run, fv_sum, zs_cnt, zs_nonzero, mirror_err, mcnt;
   int done_cnt, ab_cnt, cerr_cnt, clr_cnt, wait_cyc, exp_sum;
   logic [31:0] sof_mask, eol_mask, eof_mask;
   logic [7:0]  m_dat_log [32];

   filter_frame_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_width   (cfg_width),
      .cfg_height  (cfg_height),
      .start       (start),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted),
      .cfg_err     (cfg_err),
      .s_pixel     (s_pixel),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .f_data      (f_data),
      .f_valid     (f_valid),
      .f_clr       (f_clr),
      .f_out       (f_out),
      .f_out_valid (f_out_valid),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_sof       (m_sof),
      .m_eol       (m_eol),
      .m_eof       (m_eof)
   );

   always #5 clk = ~clk;

   // Behavioural filter: on each strobe, decide whether a result comes back
   // for the DUT to capture at the next rising edge.
   always @(negedge clk) begin
      if (f_clr) begin
         mdl_cnt     = 0;
         mdl_emit    = 0;
         f_out_valid = 1'b0;
      end else if (f_valid) begin
         if ((mdl_cnt >= mdl_skip) && (mdl_emit < mdl_limit)) begin
            f_out_valid = 1'b1;
            f_out       = 8'(8'h40 + mdl_emit);
            mdl_emit++;
         end else begin
            f_out_valid = 1'b0;
         end
         mdl_cnt++;
      end else begin
         f_out_valid = 1'b0;
      end
   end

   // Hard stop in case a wait somewhere never ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // All DUT outputs packed together for all-zero checks.
   function automatic logic [26:0] all_outs();
      return {busy, done, aborted, cfg_err, s_ready, f_valid, f_clr,
              m_valid, m_sof, m_eol, m_eof, m_data, f_data};
   endfunction

   // Reset the per-frame recording.
   task automatic clear_log();
      fv_run = 0; fv_sum = 0; zs_cnt = 0; zs_nonzero = 0; mirror_err = 0;
      mcnt = 0; done_cnt = 0; ab_cnt = 0; cerr_cnt = 0; clr_cnt = 0;
      wait_cyc = 0; exp_sum = 0;
      sof_mask = '0; eol_mask = '0; eof_mask = '0;
      for (int i = 0; i < 32; i++) m_dat_log[i] = 8'd0;
   endtask

   // Advance one cycle: sample the DUT mid-cycle, then step past the edge.
   task automatic tick();
      @(negedge clk);
      if (s_ready && (f_valid !== s_valid)) mirror_err++;
      if (f_valid && s_ready) begin
         fv_run++;
         fv_sum += int'(f_data);
      end
      if (f_valid && !s_ready) begin
         zs_cnt++;
         if (f_data != 8'd0) zs_nonzero++;
      end
      if (m_valid) begin
         if (mcnt < 32) begin
            sof_mask[mcnt[4:0]]  = m_sof;
            eol_mask[mcnt[4:0]]  = m_eol;
            eof_mask[mcnt[4:0]]  = m_eof;
            m_dat_log[mcnt[4:0]] = m_data;
         end
         mcnt++;
      end
      if (done)    done_cnt++;
      if (aborted) ab_cnt++;
      if (cfg_err) cerr_cnt++;
      if (f_clr)   clr_cnt++;
      if (busy && !s_ready && !f_valid && !f_clr) wait_cyc++;
      @(posedge clk);
      #1;
   endtask

   // Issue a legal start and step through the LOAD cycle.
   task automatic start_frame(input int w, input int h, input int limit, input int skip);
      clear_log();
      mdl_skip   = skip;
      mdl_limit  = limit;
      cfg_width  = 12'(w);
      cfg_height = 12'(h);
      start      = 1'b1;
      tick();
      start      = 1'b0;
      tick();
   endtask

   // Full frame up to the first FLUSH cycle. With gap set, s_valid toggles
   // 1/0; with mid_start set, start is raised once while the frame runs.
   task automatic run_frame(input int w, input int h, input int gap,
                            input int limit, input int skip, input int mid_start);
      int acc;
      start_frame(w, h, limit, skip);
      acc = 0;
      for (int c = 0; acc < w * h; c++) begin
         s_valid = (gap == 0) || (c % 2 == 0);
         s_pixel = 8'(acc * 7 + 3);
         start   = (mid_start != 0) && (c == 5);
         if (s_valid) begin
            exp_sum += int'(s_pixel);
            acc++;
         end
         tick();
      end
      s_valid = 1'b0;
      start   = 1'b0;
   endtask

   // Run until done (or abort) with a cycle budget, then two settling cycles.
   task automatic wait_done(input int bound);
      int i;
      i = 0;
      while ((i < bound) && (done_cnt == 0) && (ab_cnt == 0)) begin
         tick();
         i++;
      end
      n_cmp++;
      if (done_cnt == 0) begin
         n_fail++;
         $display("[TB] FAIL done_timeout: got no done within %0d cycles, required a done pulse", bound);
      end
      tick();
      tick();
   endtask

   // Reset values of every output.
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (all_outs() !== 27'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got %h required 0", all_outs());
      end
      rst = 1'b0;
      clear_log();
      tick();
      n_cmp++;
      if (all_outs() !== 27'd0) begin
         n_fail++;
         $display("[TB] FAIL idle_after_reset: got %h required 0", all_outs());
      end
   endtask

   // Illegal geometries raise a single cfg_err pulse and never go busy.
   task automatic test_cfg_err();
      int ws [3] = '{2, 1025, 4};
      int hs [3] = '{3, 3, 2};
      clear_log();
      for (int i = 0; i < 3; i++) begin
         cfg_width  = 12'(ws[i]);
         cfg_height = 12'(hs[i]);
         start      = 1'b1;
         tick();
         start      = 1'b0;
         n_cmp++;
         if ({cfg_err, busy} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL cfg_err_pulse[%0d]: got cfg_err,busy=%b required 10", i, {cfg_err, busy});
         end
         tick();
      end
      n_cmp++;
      if ({cfg_err, busy} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL cfg_err_clear: got cfg_err,busy=%b required 00", {cfg_err, busy});
      end
      n_cmp++;
      if (cerr_cnt !== 3) begin
         n_fail++;
         $display("[TB] FAIL cfg_err_count: got %0d required 3", cerr_cnt);
      end
   endtask

   // Legal extremes of width, start beating abort in IDLE, abort from LOAD.
   task automatic test_cfg_bounds();
      clear_log();
      mdl_skip   = 1000;
      cfg_width  = 12'd1024;
      cfg_height = 12'd3;
      start      = 1'b1;
      abort      = 1'b1;
      tick();
      start      = 1'b0;
      abort      = 1'b0;
      n_cmp++;
      if ({busy, f_clr, aborted, cfg_err} !== 4'b1100) begin
         n_fail++;
         $display("[TB] FAIL start_over_abort: got busy,f_clr,aborted,cfg_err=%b required 1100",
                  {busy, f_clr, aborted, cfg_err});
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp++;
      if ({busy, aborted, done} !== 3'b010) begin
         n_fail++;
         $display("[TB] FAIL abort_in_load: got busy,aborted,done=%b required 010", {busy, aborted, done});
      end
      tick();
      cfg_width = 12'd3;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      n_cmp++;
      if ({busy, cfg_err} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL width3_legal: got busy,cfg_err=%b required 10", {busy, cfg_err});
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
   endtask

   // W=4 H=3 frame without gaps; the filter returns more results than
   // expected so the surplus must be discarded.
   task automatic test_basic();
      run_frame(4, 3, 0, 100, 8, 0);
      n_cmp++;
      if ({s_ready, f_valid, f_data} !== {1'b0, 1'b1, 8'h00}) begin
         n_fail++;
         $display("[TB] FAIL basic_flush_entry: got s_ready,f_valid,f_data=%b,%b,%h required 0,1,00",
                  s_ready, f_valid, f_data);
      end
      wait_done(60);
      n_cmp++;
      if (clr_cnt !== 1) begin n_fail++; $display("[TB] FAIL basic_clr_cycles: got %0d required 1", clr_cnt); end
      n_cmp++;
      if (fv_run !== 12) begin n_fail++; $display("[TB] FAIL basic_run_strobes: got %0d required 12", fv_run); end
      n_cmp++;
      if (fv_sum !== exp_sum) begin n_fail++; $display("[TB] FAIL basic_pixel_sum: got %0d required %0d", fv_sum, exp_sum); end
      n_cmp++;
      if ({zs_cnt, zs_nonzero} !== {32'd2, 32'd0}) begin
         n_fail++;
         $display("[TB] FAIL basic_zero_strobes: got %0d (nonzero %0d) required 2 (nonzero 0)", zs_cnt, zs_nonzero);
      end
      n_cmp++;
      if (mcnt !== 4) begin n_fail++; $display("[TB] FAIL basic_beats: got %0d required 4", mcnt); end
      n_cmp++;
      if ({sof_mask, eol_mask, eof_mask} !== {32'h1, 32'h8, 32'h8}) begin
         n_fail++;
         $display("[TB] FAIL basic_tags: got sof=%h eol=%h eof=%h required 1,8,8", sof_mask, eol_mask, eof_mask);
      end
      n_cmp++;
      if ({m_dat_log[0], m_dat_log[3]} !== 16'h4043) begin
         n_fail++;
         $display("[TB] FAIL basic_data: got %h,%h required 40,43", m_dat_log[0], m_dat_log[3]);
      end
      n_cmp++;
      if (wait_cyc !== 1) begin n_fail++; $display("[TB] FAIL basic_wait_cycles: got %0d required 1", wait_cyc); end
      n_cmp++;
      if ({done_cnt, busy} !== {32'd1, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL basic_done: got done_cnt=%0d busy=%b required 1,0", done_cnt, busy);
      end
   endtask

   // W=8 H=4 with s_valid toggling and a start raised mid-frame.
   task automatic test_toggle();
      run_frame(8, 4, 1, 100, 18, 1);
      n_cmp++;
      if ({s_ready, f_valid, f_data} !== {1'b0, 1'b1, 8'h00}) begin
         n_fail++;
         $display("[TB] FAIL toggle_flush_entry: got s_ready,f_valid,f_data=%b,%b,%h required 0,1,00",
                  s_ready, f_valid, f_data);
      end
      wait_done(80);
      n_cmp++;
      if (mirror_err !== 0) begin n_fail++; $display("[TB] FAIL toggle_mirror: got %0d errors required 0", mirror_err); end
      n_cmp++;
      if ({fv_run, fv_sum} !== {32'd32, exp_sum}) begin
         n_fail++;
         $display("[TB] FAIL toggle_strobes: got %0d sum %0d required 32 sum %0d", fv_run, fv_sum, exp_sum);
      end
      n_cmp++;
      if (mcnt !== 16) begin n_fail++; $display("[TB] FAIL toggle_beats: got %0d required 16", mcnt); end
      n_cmp++;
      if ({sof_mask, eol_mask, eof_mask} !== {32'h1, 32'h8080, 32'h8000}) begin
         n_fail++;
         $display("[TB] FAIL toggle_tags: got sof=%h eol=%h eof=%h required 1,8080,8000", sof_mask, eol_mask, eof_mask);
      end
      n_cmp++;
      if (m_dat_log[15] !== 8'h4F) begin n_fail++; $display("[TB] FAIL toggle_last_data: got %h required 4f", m_dat_log[15]); end
      n_cmp++;
      if ({clr_cnt, cerr_cnt, done_cnt} !== {32'd1, 32'd0, 32'd1}) begin
         n_fail++;
         $display("[TB] FAIL toggle_busy_start: got clr=%0d cfg_err=%0d done=%0d required 1,0,1", clr_cnt, cerr_cnt, done_cnt);
      end
   endtask

   // Filter returns only 3 of 4 results: drain timeout forces completion.
   task automatic test_timeout();
      run_frame(4, 3, 0, 3, 8, 0);
      wait_done(60);
      n_cmp++;
      if (mcnt !== 3) begin n_fail++; $display("[TB] FAIL timeout_beats: got %0d required 3", mcnt); end
      n_cmp++;
      if (eof_mask !== 32'h0) begin n_fail++; $display("[TB] FAIL timeout_no_eof: got %h required 0", eof_mask); end
      n_cmp++;
      if (wait_cyc !== 16) begin n_fail++; $display("[TB] FAIL timeout_wait_cycles: got %0d required 16", wait_cyc); end
      n_cmp++;
      if ({done_cnt, busy} !== {32'd1, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL timeout_done: got done_cnt=%0d busy=%b required 1,0", done_cnt, busy);
      end
   endtask

   // Abort on the fifth transfer, then a clean frame afterwards.
   task automatic test_abort();
      start_frame(4, 3, 100, 1000);
      for (int k = 0; k < 5; k++) begin
         s_valid = 1'b1;
         s_pixel = 8'(k + 1);
         abort   = (k == 4);
         tick();
      end
      abort   = 1'b0;
      s_valid = 1'b0;
      n_cmp++;
      if ({aborted, busy, s_ready, done, m_valid} !== 5'b10000) begin
         n_fail++;
         $display("[TB] FAIL abort_response: got aborted,busy,s_ready,done,m_valid=%b required 10000",
                  {aborted, busy, s_ready, done, m_valid});
      end
      tick();
      n_cmp++;
      if (aborted !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_pulse_width: got %b required 0", aborted); end
      run_frame(4, 3, 0, 100, 8, 0);
      wait_done(60);
      n_cmp++;
      if ({mcnt, fv_run, done_cnt, ab_cnt} !== {32'd4, 32'd12, 32'd1, 32'd0}) begin
         n_fail++;
         $display("[TB] FAIL abort_recovery: got beats=%0d strobes=%0d done=%0d aborted=%0d required 4,12,1,0",
                  mcnt, fv_run, done_cnt, ab_cnt);
      end
      n_cmp++;
      if ({sof_mask, eof_mask} !== {32'h1, 32'h8}) begin
         n_fail++;
         $display("[TB] FAIL abort_recovery_tags: got sof=%h eof=%h required 1,8", sof_mask, eof_mask);
      end
   endtask

   // Reset pulse while flushing: everything clears, no completion follows.
   task automatic test_rst_flush();
      run_frame(4, 3, 0, 100, 8, 0);
      rst = 1'b1;
      tick();
      n_cmp++;
      if (all_outs() !== 27'd0) begin
         n_fail++;
         $display("[TB] FAIL rst_flush_outputs: got %h required 0", all_outs());
      end
      rst = 1'b0;
      repeat (20) tick();
      n_cmp++;
      if ({done_cnt, ab_cnt, busy} !== {32'd0, 32'd0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL rst_flush_no_pulse: got done=%0d aborted=%0d busy=%b required 0,0,0",
                  done_cnt, ab_cnt, busy);
      end
   endtask

   initial begin
      $display("[TB] filter_frame_ctrl directed tests");
      test_reset();
      test_cfg_err();
      test_cfg_bounds();
      test_basic();
      test_toggle();
      test_timeout();
      test_abort();
      test_rst_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
